// File: rtl/pb_ser_pkg.sv
// Shared types and size limits for the protobuf field byte serializer.
package pb_ser_pkg;

    localparam int PB_MAX_FIELD_BYTES = 15;
    localparam int PB_MAX_KEY_BYTES   = 5;
    localparam int PB_MAX_VAL_BYTES   = 10;

    typedef logic [119:0] pb_field_t;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_e;

endpackage

// File: rtl/pb_varint_len_detect.sv
// Finds the key and value varint boundaries of an encoded field from the
// continuation bits (bit 7 of each byte). Purely combinational.
module pb_varint_len_detect
    import pb_ser_pkg::*;
(
    input  pb_field_t   in_field,
    output logic [2:0]  klen,
    output logic [3:0]  vlen,
    output logic [3:0]  total,
    output logic        malformed
);

    logic [PB_MAX_FIELD_BYTES-1:0] contBits;
    logic                          keyFound;
    logic                          valFound;
    logic [3:0]                    scanIdx;

    // Scan for the first clear continuation bit in the key, then in the value.
    always_comb begin
        contBits = '0;
        keyFound = 1'b0;
        valFound = 1'b0;
        klen     = '0;
        vlen     = '0;
        scanIdx  = '0;

        for (int b = 0; b < PB_MAX_FIELD_BYTES; b++) begin
            contBits[b] = in_field[8*b+7];
        end

        for (int k = 0; k < PB_MAX_KEY_BYTES; k++) begin
            if (!keyFound && !contBits[k]) begin
                keyFound = 1'b1;
                klen     = 3'(k + 1);
            end
        end

        for (int v = 0; v < PB_MAX_VAL_BYTES; v++) begin
            scanIdx = 4'(klen) + 4'(v);
            if (keyFound && !valFound && !contBits[scanIdx]) begin
                valFound = 1'b1;
                vlen     = 4'(v + 1);
            end
        end

        total     = 4'(klen) + vlen;
        malformed = !(keyFound && valFound);
    end

endmodule

// File: rtl/pb_field_byte_serializer.sv
// Streams one encoded protobuf field (key varint + value varint) out one byte
// per cycle on a valid/ready interface; malformed fields are dropped with an
// err pulse. Define PB_SER_BYTE_COUNT_EN to add the running byte counter.
module pb_field_byte_serializer
    import pb_ser_pkg::*;
`ifdef PB_SER_BYTE_COUNT_EN
#(
    parameter int COUNT_W = 32
)
`endif
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  pb_field_t           in_field,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_byte,
    output logic                out_last,
    output logic                err
`ifdef PB_SER_BYTE_COUNT_EN
    ,
    output logic [COUNT_W-1:0]  byte_count,
    input  logic                count_clr
`endif
);

    ser_state_e  state_q, state_d;
    pb_field_t   field_q, field_d;
    logic [3:0]  total_q, total_d;
    logic [3:0]  idx_q, idx_d;
    logic        err_q, err_d;

    logic [3:0]  fieldTotal;
    logic        fieldMalformed;

    pb_varint_len_detect u_len_detect (
        .in_field  (in_field),
        .klen      (),
        .vlen      (),
        .total     (fieldTotal),
        .malformed (fieldMalformed)
    );

    // Next-state and outputs; a finishing last byte can hand over to a new field in the same cycle.
    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        total_d   = total_q;
        idx_d     = idx_q;
        err_d     = 1'b0;

        out_valid = (state_q == SER_SEND);
        out_byte  = out_valid ? field_q[{idx_q, 3'b000} +: 8] : 8'h00;
        out_last  = out_valid && (idx_q == (total_q - 4'd1));
        in_ready  = (state_q == SER_IDLE) || (out_last && out_ready);

        if ((state_q == SER_SEND) && out_ready) begin
            if (out_last) begin
                state_d = SER_IDLE;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end

        if (in_valid && in_ready) begin
            if (fieldMalformed) begin
                err_d = 1'b1;
            end else begin
                field_d = in_field;
                total_d = fieldTotal;
                idx_d   = '0;
                state_d = SER_SEND;
            end
        end
    end

    // State and holding registers; reset discards any partially sent field.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            field_q <= '0;
            total_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            total_q <= total_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

`ifdef PB_SER_BYTE_COUNT_EN
    logic [COUNT_W-1:0] byteCount_q, byteCount_d;
    logic               byteXfer;

    // Running count of transferred bytes; a clear coinciding with a transfer counts that byte.
    always_comb begin
        byteXfer    = out_valid && out_ready;
        byteCount_d = byteCount_q;
        if (count_clr) begin
            byteCount_d = byteXfer ? COUNT_W'(1) : '0;
        end else if (byteXfer) begin
            byteCount_d = byteCount_q + COUNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteCount_q <= '0;
        end else begin
            byteCount_q <= byteCount_d;
        end
    end

    assign byte_count = byteCount_q;
`endif

endmodule

// File: tb/tb_pb_field_byte_serializer.sv
// Directed testbench for pb_field_byte_serializer. Byte counter checks are
// included when PB_SER_BYTE_COUNT_EN is defined.
module tb_pb_field_byte_serializer;
    import pb_ser_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    pb_field_t  in_field;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;
    logic       err;
`ifdef PB_SER_BYTE_COUNT_EN
    logic [31:0] byte_count;
    logic        count_clr;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    pb_field_byte_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_field  (in_field),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .err       (err)
`ifdef PB_SER_BYTE_COUNT_EN
        ,
        .byte_count(byte_count),
        .count_clr (count_clr)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input pb_field_t field, input logic ready);
        in_valid  = valid;
        in_field  = field;
        out_ready = ready;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectByte(input string tag, input logic [7:0] b, input logic last);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".byte"},  32'(out_byte),  32'(b));
        checkOutput({tag, ".last"},  32'(out_last),  32'(last));
    endtask

    // Offer a field, then check nBytes bytes; with stall set, out_ready alternates 0/1.
    task automatic sendAndCheck(input string tag, input pb_field_t f, input int nBytes, input bit stall);
        int idx;
        bit readyNow;
        idx = 0;
        applyStimulus(1'b1, f, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        for (int cyc = 0; (cyc < 4 * nBytes) && (idx < nBytes); cyc++) begin
            expectByte($sformatf("%s[%0d]", tag, idx), f[8*idx +: 8], idx == nBytes - 1);
            readyNow  = stall ? cyc[0] : 1'b1;
            out_ready = readyNow;
            stepCycle();
            if (readyNow) idx++;
        end
        checkOutput({tag, ".bytes"}, 32'(idx), 32'(nBytes));
        checkOutput({tag, ".done"}, 32'(out_valid), 32'd0);
        out_ready = 1'b1;
    endtask

    pb_field_t allOnes;
    pb_field_t longVal;
    pb_field_t maxField;
    pb_field_t noValTerm;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        allOnes = '1;

        longVal = '0;
        longVal[7:0]   = 8'h08;
        longVal[15:8]  = 8'hFE;
        for (int i = 2; i < 10; i++) longVal[8*i +: 8] = 8'hFF;
        longVal[87:80] = 8'h01;

        maxField = '0;
        for (int i = 0; i < 4; i++) maxField[8*i +: 8] = 8'h80;
        maxField[39:32] = 8'h08;
        for (int i = 5; i < 14; i++) maxField[8*i +: 8] = 8'hFF;
        maxField[119:112] = 8'h01;

        noValTerm = '0;
        noValTerm[7:0] = 8'h08;
        for (int i = 1; i < 11; i++) noValTerm[8*i +: 8] = 8'hFF;

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
`ifdef PB_SER_BYTE_COUNT_EN
        count_clr = 1'b0;
`endif
        repeat (3) stepCycle();
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.out_byte",  32'(out_byte),  32'd0);
        checkOutput("rst.out_last",  32'(out_last),  32'd0);
        checkOutput("rst.err",       32'(err),       32'd0);
        checkOutput("rst.in_ready",  32'(in_ready),  32'd1);
`ifdef PB_SER_BYTE_COUNT_EN
        checkOutput("rst.byte_count", byte_count, 32'd0);
`endif
        rst = 1'b0;
        stepCycle();

        sendAndCheck("s1", 120'h019608, 3, 1'b0);
`ifdef PB_SER_BYTE_COUNT_EN
        checkOutput("s1.byte_count", byte_count, 32'd3);
`endif

        // Back-to-back 2-byte fields, no bubble between them.
        applyStimulus(1'b1, 120'h0310, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        expectByte("s2.a0", 8'h10, 1'b0);
        checkOutput("s2.a0.in_ready", 32'(in_ready), 32'd0);
        stepCycle();
        expectByte("s2.a1", 8'h03, 1'b1);
        checkOutput("s2.a1.in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 120'h0210, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        expectByte("s2.b0", 8'h10, 1'b0);
        stepCycle();
        expectByte("s2.b1", 8'h02, 1'b1);
        stepCycle();
        checkOutput("s2.idle", 32'(out_valid), 32'd0);

        sendAndCheck("s3", longVal, 11, 1'b1);
        sendAndCheck("max15", maxField, 15, 1'b0);

        // Malformed: no terminator anywhere.
        applyStimulus(1'b1, allOnes, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("s4.err",       32'(err),       32'd1);
        checkOutput("s4.out_valid", 32'(out_valid), 32'd0);
        checkOutput("s4.in_ready",  32'(in_ready),  32'd1);
        stepCycle();
        checkOutput("s4.err_end",   32'(err),       32'd0);
        checkOutput("s4.idle",      32'(out_valid), 32'd0);

        // Malformed: key fine, value has no terminator within 10 bytes.
        applyStimulus(1'b1, noValTerm, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("noval.err",       32'(err),       32'd1);
        checkOutput("noval.out_valid", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("noval.err_end",   32'(err),       32'd0);

        // Well-formed field followed immediately by a malformed one.
        applyStimulus(1'b1, 120'h0310, 1'b1);
        stepCycle();
        applyStimulus(1'b1, allOnes, 1'b1);
        expectByte("wm.0", 8'h10, 1'b0);
        checkOutput("wm.0.err", 32'(err), 32'd0);
        stepCycle();
        expectByte("wm.1", 8'h03, 1'b1);
        checkOutput("wm.1.err", 32'(err), 32'd0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("wm.err",       32'(err),       32'd1);
        checkOutput("wm.out_valid", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("wm.err_end",   32'(err),       32'd0);
        checkOutput("wm.in_ready",  32'(in_ready),  32'd1);

        // Reset in the middle of a 3-byte field.
        applyStimulus(1'b1, 120'h019608, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        expectByte("s5.0", 8'h08, 1'b0);
        stepCycle();
        expectByte("s5.1", 8'h96, 1'b0);
        rst = 1'b1;
        stepCycle();
        checkOutput("s5.out_valid", 32'(out_valid), 32'd0);
        checkOutput("s5.out_byte",  32'(out_byte),  32'd0);
`ifdef PB_SER_BYTE_COUNT_EN
        checkOutput("s5.byte_count", byte_count, 32'd0);
`endif
        rst = 1'b0;
        stepCycle();
        checkOutput("s5.idle",     32'(out_valid), 32'd0);
        checkOutput("s5.in_ready", 32'(in_ready),  32'd1);

`ifdef PB_SER_BYTE_COUNT_EN
        // Clear coinciding with a transfer yields a count of 1.
        applyStimulus(1'b1, 120'h0310, 1'b1);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b1);
        count_clr = 1'b1;
        stepCycle();
        count_clr = 1'b0;
        checkOutput("s6.clr_xfer", byte_count, 32'd1);
        stepCycle();
        checkOutput("s6.after", byte_count, 32'd2);
        count_clr = 1'b1;
        stepCycle();
        count_clr = 1'b0;
        checkOutput("s6.clr_only", byte_count, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
